multi_adder_display: RTL
========================

Name: multi_adder_display

Overview:
- Parametrised successor to the two-operand adder/touchscreen front end.
- Holds NUM_OPS operand registers loaded from the lcd_module touchscreen input, selected by input_sel.
- Computes their sum plus carry-in serially, one operand per cycle, and counts carries.
- Drives the lcd_module display-slot interface with all operands, the result and the carry count.

Parameters:
- WIDTH, 32: operand/result width, 1..32; input_value low WIDTH bits used.
- NUM_OPS, 4: operand count, 2..16.
- SLOT_BASE, 4: display slot of operand 0; SLOT_BASE+NUM_OPS+1 must be <= 44.

Ports:
- clk  in  1  system clock (10 MHz).
- reset  in  1  synchronous, active-high reset.
- input_sel  in  4  target operand index.
- sw_cin  in  1  carry-in switch.
- input_valid  in  1  one-cycle strobe from lcd_module.
- input_value  in  32  value entered on touchscreen.
- display_number  in  6  slot being drawn by lcd_module.
- display_valid  out  1  slot populated.
- display_name  out  40  5-char ASCII slot name.
- display_value  out  32  slot value, zero-extended.
- result  out  WIDTH  committed sum, mod 2^WIDTH.
- carry_cnt  out  $clog2(NUM_OPS)+1  committed carry-out count (upper sum bits).
- led_cout  out  1  carry_cnt != 0.
- result_valid  out  1  result reflects current operands and cin.
- busy  out  1  accumulation in progress.

Behaviour:
- Reset (sync, any state including mid-accumulation):
  - all operands 0, cin_q 0, state IDLE, idx 0, accumulators 0.
  - result 0, carry_cnt 0, result_valid 1, busy 0.
  - display outputs 0.
- Write: at an edge with input_valid=1 and input_sel<NUM_OPS, op[input_sel] <= input_value[WIDTH-1:0]. input_sel>=NUM_OPS: write dropped, no restart.
- cin_q registers sw_cin every cycle. Trigger = accepted write OR (sw_cin != cin_q).
- FSM states IDLE, ACCUM, DONE:
  - Trigger in any state: next state ACCUM, idx <= 0, acc <= cin (zero-extended, the new sw_cin value), cacc <= 0. result_valid <= 0 and busy <= 1 from the same edge.
  - A trigger during ACCUM aborts and restarts. Write and cin change in the same cycle cause a single restart.
  - ACCUM, each edge: {c, acc} <= acc + op[idx] (WIDTH+1-bit add), cacc <= cacc + c, idx <= idx+1. The operand value used is the one registered before that edge.
  - At idx==NUM_OPS-1: next state DONE; result/carry_cnt <= final acc/cacc in the same edge; result_valid <= 1; busy <= 0.
  - Latency: trigger edge T, result committed at edge T+NUM_OPS.
  - DONE: hold. It equals IDLE except that outputs persist. result/carry_cnt change only at commit.
- Display (registered, 1-cycle latency from display_number):
  - SLOT_BASE+i, i<NUM_OPS: valid 1, name "OP_" plus two decimal ASCII digits of i, value op[i].
  - SLOT_BASE+NUM_OPS: "RESUL", result.
  - SLOT_BASE+NUM_OPS+1: "CARRY", carry_cnt.
  - Other slots: valid 0, name 0, value 0.
  - Values are zero-extended to 32 bits. Display shows committed values even while busy.

Decomposition:
- Package multi_adder_pkg:
  - FSM state enum.
  - ASCII name constants "RESUL", "CARRY", "OP_".
  - Function building the two-digit operand name.
  - Slot-range check function.
- Sub-module multi_adder_slot_mux: combinational slot decode plus the output register stage. Keeps the accumulator FSM separate.

Test Plan:
- Reset then no input -> slot 4 gives valid 1, "OP_00", 0. Slot 8 gives "RESUL", 0. Slot 9 gives "CARRY", 0. Slot 3 gives valid 0. result_valid 1.
- Write op0=0xFFFFFFFF, op1=0x00000001, cin 0 -> 4 cycles after the last write: result 0, carry_cnt 1, led_cout 1. busy high for exactly 4 cycles.
- sw_cin=1, ops 0x10/0x20/0x30/0x40 -> result 0xA1, carry_cnt 0. result_valid 0 during ACCUM.
- Write op2=0x100 on the 2nd ACCUM cycle of a run with ops 1/2/3/4 -> restart. Commit 4 cycles after that write, result 0x107. No intermediate commit.
- input_sel=5 with input_valid (NUM_OPS=4) -> operands unchanged, busy stays 0, result unchanged.
- WIDTH=8 instance, four writes of 0xFF -> result 0xFC, carry_cnt 3. Slot 8 value 0x000000FC. Reset asserted mid-ACCUM -> next cycle result 0, busy 0, result_valid 1.

Source files
------------

// File: rtl/multi_adder_pkg.sv
// multi_adder_pkg
// Shared definitions for the multi-operand adder / touchscreen front end:
//   - FSM state encoding (IDLE, ACCUM, DONE)
//   - ASCII display-name constants for the result, carry and operand slots
//   - op_name():       builds "OP_nn" with a two-digit decimal operand index
//   - slot_in_range(): true when a slot number falls inside [base, base+count)
package multi_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ACCUM = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  localparam logic [39:0] NAME_RESUL = "RESUL";
  localparam logic [39:0] NAME_CARRY = "CARRY";
  localparam logic [23:0] NAME_OP    = "OP_";

  // Operand indices never exceed 15, so two decimal digits always suffice.
  function automatic logic [39:0] op_name(input int index);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = 8'h30 + 8'(index / 10);
    ones = 8'h30 + 8'(index % 10);
    return {NAME_OP, tens, ones};
  endfunction

  function automatic logic slot_in_range(input int slot, input int base, input int count);
    return (slot >= base) && (slot < base + count);
  endfunction

endpackage

// File: rtl/multi_adder_slot_mux.sv
// multi_adder_slot_mux
// Decodes the slot number requested by lcd_module and registers the slot's
// valid flag, 5-character name and zero-extended value (one cycle latency).
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   display_number   slot currently being drawn
//   ops              all operand registers
//   result           committed sum
//   carry_cnt        committed carry count
//   display_valid    slot populated
//   display_name     ASCII slot name (5 chars)
//   display_value    slot value, zero-extended to 32 bits
module multi_adder_slot_mux
  import multi_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_OPS   = 4,
  parameter int SLOT_BASE = 4,
  parameter int CW        = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [5:0]                      display_number,
  input  logic [NUM_OPS-1:0][WIDTH-1:0]   ops,
  input  logic [WIDTH-1:0]                result,
  input  logic [CW-1:0]                   carry_cnt,
  output logic                            display_valid,
  output logic [39:0]                     display_name,
  output logic [31:0]                     display_value
);

  int          slot;
  logic        next_valid;
  logic [39:0] next_name;
  logic [31:0] next_value;

  always_comb begin
    slot       = int'(display_number);
    next_valid = 1'b0;
    next_name  = '0;
    next_value = '0;
    if (slot_in_range(slot, SLOT_BASE, NUM_OPS)) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (slot == SLOT_BASE + i) begin
          next_valid = 1'b1;
          next_name  = op_name(i);
          next_value = 32'(ops[i]);
        end
      end
    end else if (slot == SLOT_BASE + NUM_OPS) begin
      next_valid = 1'b1;
      next_name  = NAME_RESUL;
      next_value = 32'(result);
    end else if (slot == SLOT_BASE + NUM_OPS + 1) begin
      next_valid = 1'b1;
      next_name  = NAME_CARRY;
      next_value = 32'(carry_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      display_valid <= next_valid;
      display_name  <= next_name;
      display_value <= next_value;
    end
  end

endmodule

// File: rtl/multi_adder_display.sv
// multi_adder_display
// Holds NUM_OPS operands written from the touchscreen, sums them plus a
// carry-in serially (one operand per cycle), counts carry-outs and exposes
// everything on the lcd_module display-slot interface.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   input_sel        operand index for a touchscreen write
//   sw_cin           carry-in switch
//   input_valid      one-cycle write strobe
//   input_value      touchscreen value (low WIDTH bits used)
//   display_number   slot being drawn
//   display_valid/name/value  registered slot contents
//   result, carry_cnt committed sum and carry count
//   led_cout         carry count non-zero
//   result_valid     result matches current operands and carry-in
//   busy             accumulation in progress
module multi_adder_display
  import multi_adder_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_OPS   = 4,
  parameter int SLOT_BASE = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 input_sel,
  input  logic                       sw_cin,
  input  logic                       input_valid,
  input  logic [31:0]                input_value,
  input  logic [5:0]                 display_number,
  output logic                       display_valid,
  output logic [39:0]                display_name,
  output logic [31:0]                display_value,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(NUM_OPS):0]   carry_cnt,
  output logic                       led_cout,
  output logic                       result_valid,
  output logic                       busy
);

  localparam int CW = $clog2(NUM_OPS) + 1;
  localparam int IW = $clog2(NUM_OPS);

  logic [NUM_OPS-1:0][WIDTH-1:0] ops;
  logic                          cin_q;
  state_t                        state;
  logic [IW-1:0]                 idx;
  logic [WIDTH-1:0]              acc;
  logic [CW-1:0]                 cacc;
  logic                          write_ok;
  logic                          trigger;
  logic [WIDTH:0]                step_sum;
  logic [CW-1:0]                 step_cacc;

  assign write_ok  = input_valid && (int'(input_sel) < NUM_OPS);
  assign trigger   = write_ok || (sw_cin != cin_q);
  assign step_sum  = {1'b0, acc} + {1'b0, ops[idx]};
  assign step_cacc = cacc + CW'(step_sum[WIDTH]);
  assign led_cout  = (carry_cnt != '0);

  // Upper touchscreen bits are intentionally ignored for narrow instances.
  if (WIDTH < 32) begin : g_narrow
    logic unused_value_bits;
    assign unused_value_bits = ^input_value[31:WIDTH];
  end

  // Operand registers; writes to indices beyond NUM_OPS are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ops <= '0;
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (write_ok && (input_sel == 4'(i))) begin
          ops[i] <= input_value[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cin_q <= 1'b0;
    end else begin
      cin_q <= sw_cin;
    end
  end

  // Serial accumulator. A trigger always wins over an accumulation step so
  // any change mid-run restarts from operand 0 with the fresh carry-in. The
  // final step commits in the same edge it computes the last partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      acc          <= '0;
      cacc         <= '0;
      result       <= '0;
      carry_cnt    <= '0;
      result_valid <= 1'b1;
      busy         <= 1'b0;
    end else if (trigger) begin
      state        <= ST_ACCUM;
      idx          <= '0;
      acc          <= WIDTH'(sw_cin);
      cacc         <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b1;
    end else if (state == ST_ACCUM) begin
      acc  <= step_sum[WIDTH-1:0];
      cacc <= step_cacc;
      idx  <= idx + 1'b1;
      if (idx == IW'(NUM_OPS - 1)) begin
        state        <= ST_DONE;
        result       <= step_sum[WIDTH-1:0];
        carry_cnt    <= step_cacc;
        result_valid <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

  multi_adder_slot_mux #(
    .WIDTH     (WIDTH),
    .NUM_OPS   (NUM_OPS),
    .SLOT_BASE (SLOT_BASE),
    .CW        (CW)
  ) u_slot_mux (
    .clk            (clk),
    .reset          (reset),
    .display_number (display_number),
    .ops            (ops),
    .result         (result),
    .carry_cnt      (carry_cnt),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value)
  );

endmodule
